bcd_updn_cnt: RTL and testbench
===============================

BCD_UPDN_CNT -- requirements
Module: bcd_updn_cnt

Interface
REQ-001 SHALL provide parameter DIGITS, default 2, number of BCD digits (legal range 1..8).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port clr  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 SHALL provide port en  input  1  count enable; no count step when low.
REQ-005 SHALL provide port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 SHALL provide port ld  input  1  synchronous parallel load strobe.
REQ-007 SHALL provide port din  input  4*DIGITS  load value, digit 0 in bits [3:0].
REQ-008 SHALL provide port q  output  4*DIGITS  registered BCD count, digit 0 = least significant.
REQ-009 SHALL provide port cn  output  1  registered carry pulse on up-wrap.
REQ-010 SHALL provide port bw  output  1  registered borrow pulse on down-wrap.
REQ-011 SHALL provide port tc  output  1  combinational terminal count: q all 9s when up=1, all 0s when up=0.

Function
REQ-012 Priority per edge SHALL be clr > ld > en; en=0 with ld=0 SHALL hold q and drive cn=bw=0.
REQ-013 ld=1 SHALL load din into q next edge regardless of en; any din digit >9 SHALL load as 9; cn=bw=0.
REQ-014 en=1, up=1 SHALL increment the decimal value by 1 in one cycle; digit k steps only when digits 0..k-1 are all 9, a stepped digit at 9 SHALL become 0.
REQ-015 en=1, up=0 SHALL decrement the decimal value by 1; digit k steps only when digits 0..k-1 are all 0, a stepped digit at 0 SHALL become 9.
REQ-016 Up-wrap (all 9s -> all 0s) SHALL set cn=1 for exactly the one cycle in which q shows 0; all other cycles cn=0.
REQ-017 Down-wrap (all 0s -> all 9s) SHALL set bw=1 for exactly the one cycle in which q shows all 9s; otherwise bw=0.
REQ-018 Each q digit SHALL never hold a value >9 in any cycle.
REQ-019 Changing up between cycles SHALL take effect on the next enabled edge with no extra latency.

Reset
REQ-020 clr=1 at a rising edge SHALL set q=0, cn=0, bw=0, overriding ld and en, including mid-count and during a wrap cycle.
REQ-021 No asynchronous reset path SHALL exist; clr between edges SHALL have no effect.

Configuration
REQ-022 Macro BCD_SATURATE_EN defined: counter SHALL saturate (hold all 9s when counting up, hold all 0s when counting down), and cn/bw SHALL pulse for one cycle on the first attempted step beyond the limit only.
REQ-023 Macro BCD_SATURATE_EN undefined: counter SHALL wrap per REQ-014..REQ-017.

Structure
REQ-024 Shared package bcd_pkg SHALL hold BCD_MAX (4'd9), BCD_MIN (4'd0), BCD_W (4) and the digit type.
REQ-025 Sub-module bcd_digit SHALL implement one digit: inputs step, up, load value, load; outputs digit value and terminal flag (at 9 when up, at 0 when down); instantiated DIGITS times via generate, terminal flags ANDed to form the ripple enable.

Verification (DIGITS=3 unless noted)
REQ-026 clr=1 one edge with q=457 -> q=000, cn=0, bw=0 next cycle.
REQ-027 ld=1 din=0x998, then en=1 up=1 for 3 edges -> q=999, 000, 001; cn=1 only in the cycle q=000; tc=1 while q=999.
REQ-028 ld=1 din=0x001, en=1 up=0 for 3 edges -> q=000, 999, 998; bw=1 only in the cycle q=999.
REQ-029 ld=1 din=0xAF3 -> q=0x993; ld=1 and en=1 in the same edge -> load wins.
REQ-030 Count up from 000 for 1000 edges with random en gaps -> q matches decimal model every cycle, exactly one cn pulse.
REQ-031 BCD_SATURATE_EN defined, q=999, up=1 en=1 for 3 edges -> q stays 999, cn=1 in first cycle only.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit constants, digit type and load clamp helper
package bcd_pkg;
   localparam int BCD_W = 4;
   typedef logic [BCD_W-1:0] digit_t;
   localparam digit_t BCD_MAX = 4'd9;
   localparam digit_t BCD_MIN = 4'd0;
   function automatic digit_t bcd_clamp(input digit_t v);
      return (v > BCD_MAX) ? BCD_MAX : v;
   endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one registered BCD digit with load, up/down step and terminal flag
module bcd_digit
   import bcd_pkg::*;
(
   input  logic   clk,
   input  logic   clr,
   input  logic   step,
   input  logic   up,
   input  logic   ld,
   input  digit_t ld_val,
   output digit_t d,
   output logic   term
);
   digit_t inc;
   digit_t dec;
   assign inc  = (d == BCD_MAX) ? BCD_MIN : d + 4'd1;
   assign dec  = (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
   assign term = up ? (d == BCD_MAX) : (d == BCD_MIN);
   // digit register: clear beats load beats step; loads above 9 clamp to 9
   always_ff @(posedge clk) begin
      if (clr)
         d <= BCD_MIN;
      else if (ld)
         d <= bcd_clamp(ld_val);
      else if (step)
         d <= up ? inc : dec;
   end
endmodule

// File: rtl/bcd_updn_cnt.sv
// bcd_updn_cnt: DIGITS-wide BCD up/down counter with load, carry/borrow pulses
// and terminal count; define BCD_SATURATE_EN to saturate instead of wrap
module bcd_updn_cnt
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                en,
   input  logic                up,
   input  logic                ld,
   input  logic [4*DIGITS-1:0] din,
   output logic [4*DIGITS-1:0] q,
   output logic                cn,
   output logic                bw,
   output logic                tc
);
   logic [DIGITS:0]   pre;
   logic [DIGITS-1:0] term;
   logic              all_term;
   logic              step_ok;
   logic              pulse;
   assign pre[0]   = 1'b1;
   assign all_term = pre[DIGITS];
   assign tc       = all_term;
   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      assign pre[i+1] = pre[i] & term[i];
      bcd_digit u_dig (
         .clk    (clk),
         .clr    (clr),
         .step   (en & pre[i] & step_ok),
         .up     (up),
         .ld     (ld),
         .ld_val (din[4*i +: BCD_W]),
         .d      (q[4*i +: BCD_W]),
         .term   (term[i])
      );
   end
`ifdef BCD_SATURATE_EN
   logic sat;
   assign step_ok = !all_term;
   assign pulse   = en & !ld & all_term & !sat;
   // remembers that the limit was already reported so repeated attempts stay silent
   always_ff @(posedge clk) begin
      if (clr || ld)
         sat <= 1'b0;
      else if (en)
         sat <= all_term;
   end
`else
   assign step_ok = 1'b1;
   assign pulse   = en & !ld & all_term;
`endif
   // carry/borrow register: one-cycle pulse aligned with the wrapped (or held) value
   always_ff @(posedge clk) begin
      if (clr) begin
         cn <= 1'b0;
         bw <= 1'b0;
      end else begin
         cn <= pulse & up;
         bw <= pulse & !up;
      end
   end
endmodule

// File: tb/tb_bcd_updn_cnt.sv
// tb_bcd_updn_cnt: random and directed checks of bcd_updn_cnt against a decimal model
module tb_bcd_updn_cnt;
   localparam int N    = 3;
   localparam int MAXV = 999;
   logic          clk = 1'b0;
   logic          clr = 1'b0, en = 1'b0, up = 1'b1, ld = 1'b0;
   logic [4*N-1:0] din = '0;
   logic [4*N-1:0] q;
   logic          cn, bw, tc;
   int            compared = 0, mismatched = 0;
   int            mv = 0;
   bit            mcn = 0, mbw = 0, msat = 0, chk = 0;
   bcd_updn_cnt #(.DIGITS(N)) dut (
      .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld),
      .din(din), .q(q), .cn(cn), .bw(bw), .tc(tc)
   );
   always #5 clk = ~clk;
   function automatic logic [4*N-1:0] to_bcd(input int v);
      logic [4*N-1:0] r = '0;
      for (int k = 0; k < N; k++) begin
         r[4*k +: 4] = 4'((v / (10 ** k)) % 10);
      end
      return r;
   endfunction
   function automatic int ld_dec(input logic [4*N-1:0] d);
      int r = 0;
      for (int k = 0; k < N; k++) begin
         r += ((d[4*k +: 4] > 4'd9) ? 9 : int'(d[4*k +: 4])) * (10 ** k);
      end
      return r;
   endfunction
   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   always @(posedge clk) begin
      if (clr) begin
         mv = 0; mcn = 0; mbw = 0; msat = 0;
      end else if (ld) begin
         mv = ld_dec(din); mcn = 0; mbw = 0; msat = 0;
      end else if (en && ((up && mv == MAXV) || (!up && mv == 0))) begin
`ifdef BCD_SATURATE_EN
         mcn = up && !msat; mbw = !up && !msat; msat = 1;
`else
         mv = up ? 0 : MAXV; mcn = up; mbw = !up;
`endif
      end else if (en) begin
         mv = up ? mv + 1 : mv - 1; mcn = 0; mbw = 0; msat = 0;
      end else begin
         mcn = 0; mbw = 0;
      end
   end
   always @(negedge clk) begin
      if (chk) begin
         int bad = 0;
         for (int k = 0; k < N; k++) if (q[4*k +: 4] > 4'd9) bad++;
         check("q", int'(q), int'(to_bcd(mv)));
         check("cn", int'(cn), int'(mcn));
         check("bw", int'(bw), int'(mbw));
         check("tc", int'(tc), int'(up ? (mv == MAXV) : (mv == 0)));
         check("digit_range", bad, 0);
      end
   end
   task automatic cyc(input bit c, input bit e, input bit u, input bit l, input logic [4*N-1:0] d);
      #1;
      clr = c; en = e; up = u; ld = l; din = d;
      @(posedge clk);
      @(negedge clk);
   endtask
   initial begin
      int steps, ncn;
      @(negedge clk);
      cyc(1, 0, 1, 0, '0);
      chk = 1;
      check("reset_q", int'(q), 'h000);
      check("reset_cn_bw", int'({cn, bw}), 0);
      cyc(0, 0, 1, 1, 12'h457);
      check("load_457", int'(q), 'h457);
      cyc(1, 1, 1, 1, 12'h123);
      check("clr_mid_q", int'(q), 'h000);
      check("model_clr", mv, 0);
`ifndef BCD_SATURATE_EN
      cyc(0, 0, 1, 1, 12'h998);
      cyc(0, 1, 1, 0, '0);
      check("up_999", int'(q), 'h999);
      check("up_999_tc", int'(tc), 1);
      cyc(0, 1, 1, 0, '0);
      check("wrap_000", int'(q), 'h000);
      check("wrap_cn", int'(cn), 1);
      check("model_wrap", mv, 0);
      cyc(0, 1, 1, 0, '0);
      check("up_001", int'(q), 'h001);
      check("cn_drop", int'(cn), 0);
      cyc(0, 0, 0, 1, 12'h001);
      cyc(0, 1, 0, 0, '0);
      check("dn_000", int'(q), 'h000);
      cyc(0, 1, 0, 0, '0);
      check("dn_999", int'(q), 'h999);
      check("dn_bw", int'(bw), 1);
      check("model_bw", int'(mbw), 1);
      cyc(0, 1, 0, 0, '0);
      check("dn_998", int'(q), 'h998);
      check("bw_drop", int'(bw), 0);
`else
      cyc(0, 0, 1, 1, 12'h999);
      cyc(0, 1, 1, 0, '0);
      check("sat_999_a", int'(q), 'h999);
      check("sat_cn_a", int'(cn), 1);
      cyc(0, 1, 1, 0, '0);
      check("sat_999_b", int'(q), 'h999);
      check("sat_cn_b", int'(cn), 0);
      cyc(0, 1, 1, 0, '0);
      check("sat_cn_c", int'(cn), 0);
      cyc(0, 0, 0, 1, 12'h000);
      cyc(0, 1, 0, 0, '0);
      check("sat_000", int'(q), 'h000);
      check("sat_bw", int'(bw), 1);
`endif
      cyc(0, 0, 1, 1, 12'hAF3);
      check("clamp_993", int'(q), 'h993);
      check("model_clamp", mv, 993);
      cyc(0, 1, 1, 1, 12'h123);
      check("ld_over_en", int'(q), 'h123);
      cyc(1, 0, 1, 0, '0);
      steps = 0;
      ncn = 0;
      for (int i = 0; i < 5000 && steps < 1000; i++) begin
         bit e = ($urandom_range(3) != 0);
         cyc(0, e, 1, 0, '0);
         if (e) steps++;
         if (cn) ncn++;
      end
      check("run_steps", steps, 1000);
      check("run_cn_count", ncn, 1);
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(31) == 0, $urandom_range(3) != 0, $urandom_range(1) == 1,
             $urandom_range(15) == 0, 12'($urandom));
      end
      chk = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
